rx_align_checker: RTL and testbench

//  Consumes 8-bit deserialised words from the HPIO RX lane (data_to_fabric_p, clk_200m domain).

---
 rtl/rx_align_checker.sv | 198 +++++++++++++++++++
 tb/tb_rx_align_checker.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/rx_align_checker.sv
`default_nettype none
// ============================================================================
//  Module   : rx_align_checker
//  Purpose  : Word-boundary recovery and pattern checking for an 8-bit
//             deserialised loopback lane. The block bit-slips the incoming
//             words until they form an incrementing counter sequence, locks,
//             then compares every following word against the expected count
//             and accumulates error and word statistics.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i         in   1      rising-edge clock
//    rst_ni        in   1      synchronous reset, active low
//    din_i         in   8      raw deserialised word
//    din_valid_i   in   1      din_i qualifier; invalid cycles are ignored
//    cnt_clr_i     in   1      clears err_cnt_o / word_cnt_o, lock untouched
//    dout_o        out  8      aligned word (registered)
//    dout_valid_o  out  1      dout_o qualifier
//    locked_o      out  1      high while in the LOCKED state
//    rot_o         out  3      current bit-slip amount
//    err_cnt_o     out  ERR_W  mismatches seen while locked (saturating)
//    word_cnt_o    out  CNT_W  words checked while locked (saturating)
// ============================================================================
module rx_align_checker #(
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_CNT = 4,
  parameter int ERR_W      = 32,
  parameter int CNT_W      = 48
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [7:0]       din_i,
  input  logic             din_valid_i,
  input  logic             cnt_clr_i,
  output logic [7:0]       dout_o,
  output logic             dout_valid_o,
  output logic             locked_o,
  output logic [2:0]       rot_o,
  output logic [ERR_W-1:0] err_cnt_o,
  output logic [CNT_W-1:0] word_cnt_o
);

  localparam int c_match_w = $clog2(LOCK_CNT + 1);
  localparam int c_miss_w  = $clog2(UNLOCK_CNT + 1);
  localparam logic [c_match_w-1:0] c_lock_thr   = c_match_w'(LOCK_CNT);
  localparam logic [c_miss_w-1:0]  c_unlock_thr = c_miss_w'(UNLOCK_CNT);

  typedef enum logic [0:0] {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t               state_q,      state_d;
  logic [2:0]           rot_q,        rot_d;
  logic [7:0]           raw_prev_q,   raw_prev_d;
  logic [7:0]           ref_q,        ref_d;
  logic                 ref_valid_q,  ref_valid_d;
  logic [c_match_w-1:0] match_cnt_q,  match_cnt_d;
  logic [c_miss_w-1:0]  miss_cnt_q,   miss_cnt_d;
  logic [7:0]           exp_q,        exp_d;
  logic [ERR_W-1:0]     err_cnt_q,    err_cnt_d;
  logic [CNT_W-1:0]     word_cnt_q,   word_cnt_d;
  logic [7:0]           dout_q,       dout_d;
  logic                 dout_valid_q, dout_valid_d;

  logic [15:0]          w_concat;
  logic [3:0]           w_shamt;
  logic [15:0]          w_shifted;
  logic [7:0]           w_aligned;
  logic [7:0]           w_ref_inc;
  logic [c_match_w-1:0] w_match_inc;
  logic [c_miss_w-1:0]  w_miss_inc;

  // The previous raw word supplies the low-order bits that slide into the
  // current word as rot grows; rot=0 shifts by a full byte, returning din_i.
  assign w_concat    = {din_i, raw_prev_q};
  assign w_shamt     = 4'd8 - {1'b0, rot_q};
  assign w_shifted   = w_concat >> w_shamt;
  assign w_aligned   = w_shifted[7:0];
  assign w_ref_inc   = ref_q + 8'd1;
  assign w_match_inc = match_cnt_q + c_match_w'(1);
  assign w_miss_inc  = miss_cnt_q + c_miss_w'(1);

  always_comb begin
    state_d      = state_q;
    rot_d        = rot_q;
    raw_prev_d   = raw_prev_q;
    ref_d        = ref_q;
    ref_valid_d  = ref_valid_q;
    match_cnt_d  = match_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    exp_d        = exp_q;
    err_cnt_d    = err_cnt_q;
    word_cnt_d   = word_cnt_q;
    dout_d       = dout_q;
    dout_valid_d = din_valid_i;

    if (din_valid_i) begin
      raw_prev_d = din_i;
      dout_d     = w_aligned;

      case (state_q)
        ST_SEARCH: begin
          if (!ref_valid_q) begin
            // First word after a (re)start only seeds the reference.
            ref_d       = w_aligned;
            ref_valid_d = 1'b1;
          end else if (w_aligned == w_ref_inc) begin
            ref_d = w_aligned;
            if (w_match_inc == c_lock_thr) begin
              state_d     = ST_LOCKED;
              exp_d       = w_aligned + 8'd1;
              miss_cnt_d  = '0;
              match_cnt_d = '0;
            end else begin
              match_cnt_d = w_match_inc;
            end
          end else begin
            // Wrong boundary: slip one bit and rebuild the reference.
            rot_d       = rot_q + 3'd1;
            match_cnt_d = '0;
            ref_valid_d = 1'b0;
          end
        end

        ST_LOCKED: begin
          // exp free-runs so an isolated bad word costs exactly one error.
          exp_d = exp_q + 8'd1;
          if (word_cnt_q != {CNT_W{1'b1}}) begin
            word_cnt_d = word_cnt_q + CNT_W'(1);
          end
          if (w_aligned != exp_q) begin
            if (err_cnt_q != {ERR_W{1'b1}}) begin
              err_cnt_d = err_cnt_q + ERR_W'(1);
            end
            if (w_miss_inc == c_unlock_thr) begin
              state_d     = ST_SEARCH;
              match_cnt_d = '0;
              ref_valid_d = 1'b0;
              miss_cnt_d  = '0;
            end else begin
              miss_cnt_d = w_miss_inc;
            end
          end else begin
            miss_cnt_d = '0;
          end
        end

        default: state_d = ST_SEARCH;
      endcase
    end

    // Clear takes priority over any increment in the same cycle.
    if (cnt_clr_i) begin
      err_cnt_d  = '0;
      word_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= ST_SEARCH;
      rot_q        <= '0;
      raw_prev_q   <= '0;
      ref_q        <= '0;
      ref_valid_q  <= 1'b0;
      match_cnt_q  <= '0;
      miss_cnt_q   <= '0;
      exp_q        <= '0;
      err_cnt_q    <= '0;
      word_cnt_q   <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rot_q        <= rot_d;
      raw_prev_q   <= raw_prev_d;
      ref_q        <= ref_d;
      ref_valid_q  <= ref_valid_d;
      match_cnt_q  <= match_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      exp_q        <= exp_d;
      err_cnt_q    <= err_cnt_d;
      word_cnt_q   <= word_cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign dout_o       = dout_q;
  assign dout_valid_o = dout_valid_q;
  assign locked_o     = (state_q == ST_LOCKED);
  assign rot_o        = rot_q;
  assign err_cnt_o    = err_cnt_q;
  assign word_cnt_o   = word_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_rx_align_checker.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_rx_align_checker
//  Purpose  : Self-checking bench for rx_align_checker. Registered output
//             words are predicted at drive time and compared through a
//             scoreboard queue; lock/counter behaviour is checked from a
//             vector table and short hand-written sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rx_align_checker;

  logic        clk;
  logic        rst_n;
  logic [7:0]  din;
  logic        din_valid;
  logic        cnt_clr;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        locked;
  logic [2:0]  rot;
  logic [31:0] err_cnt;
  logic [47:0] word_cnt;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic       v;
    logic       chk;
    logic [7:0] d;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic [7:0]  din;
    logic        v;
    logic        clr;
    logic        lk;
    logic [31:0] err;
    logic [47:0] wc;
  } vec_t;
  vec_t tbl[8];

  rx_align_checker #(
    .LOCK_CNT  (16),
    .UNLOCK_CNT(4),
    .ERR_W     (32),
    .CNT_W     (48)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .din_i       (din),
    .din_valid_i (din_valid),
    .cnt_clr_i   (cnt_clr),
    .dout_o      (dout),
    .dout_valid_o(dout_valid),
    .locked_o    (locked),
    .rot_o       (rot),
    .err_cnt_o   (err_cnt),
    .word_cnt_o  (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #(200000 * 10);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle, push the predicted registered output, then compare
  // it against what the DUT presents just after the capturing edge.
  task automatic step(input logic [7:0] d, input logic v, input logic clr,
                      input logic rn, input logic chk, input logic [7:0] ed);
    sb_t e;
    sb_q.push_back('{v & rn, chk & v & rn, ed});
    @(negedge clk);
    din       = d;
    din_valid = v;
    cnt_clr   = clr;
    rst_n     = rn;
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 64'(1), 64'(0));
    end else begin
      e = sb_q.pop_front();
      check("dout_valid", 64'(dout_valid), 64'(e.v));
      if (e.chk) check("dout", 64'(dout), 64'(e.d));
    end
  endtask

  function automatic logic [7:0] cnt2(input int m);
    return 8'(m + 64);
  endfunction

  // Serial counter stream observed 3 bits late: each raw word carries the
  // top 5 bits of one count and the low 3 bits of the next.
  function automatic logic [7:0] slip3(input int m);
    logic [15:0] pair;
    pair = {cnt2(m + 1), cnt2(m)};
    return 8'(pair >> 3);
  endfunction

  initial begin
    int lock_m;
    logic locked_seen;

    tbl[0] = '{8'h00, 1'b1, 1'b0, 1'b1, 32'd1, 48'd1};
    tbl[1] = '{8'h56, 1'b1, 1'b0, 1'b1, 32'd1, 48'd2};
    tbl[2] = '{8'h13, 1'b0, 1'b0, 1'b1, 32'd1, 48'd2};
    tbl[3] = '{8'h57, 1'b1, 1'b0, 1'b1, 32'd1, 48'd3};
    tbl[4] = '{8'hAA, 1'b1, 1'b0, 1'b1, 32'd2, 48'd4};
    tbl[5] = '{8'hAA, 1'b1, 1'b0, 1'b1, 32'd3, 48'd5};
    tbl[6] = '{8'hAA, 1'b1, 1'b1, 1'b1, 32'd0, 48'd0};
    tbl[7] = '{8'hAA, 1'b1, 1'b0, 1'b0, 32'd1, 48'd1};

    rst_n = 1'b0; din = 8'h00; din_valid = 1'b0; cnt_clr = 1'b0;

    // Reset state, including a valid word presented during reset.
    step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    step(8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check("rst_locked", 64'(locked), 64'(0));
    check("rst_rot", 64'(rot), 64'(0));
    check("rst_err", 64'(err_cnt), 64'(0));
    check("rst_word", 64'(word_cnt), 64'(0));
    check("rst_dout", 64'(dout), 64'(0));

    // T1: aligned counter, lock after the 17th word, 1000 words clean.
    for (int i = 0; i < 1000; i++) begin
      step(8'(i), 1'b1, 1'b0, 1'b1, 1'b1, 8'(i));
      if (i == 15) check("t1_locked_w16", 64'(locked), 64'(0));
      if (i == 16) check("t1_locked_w17", 64'(locked), 64'(1));
    end
    check("t1_err", 64'(err_cnt), 64'(0));
    check("t1_word", 64'(word_cnt), 64'(983));
    check("t1_rot", 64'(rot), 64'(0));

    // Continue through the 0xFF->0x00 wrap up to just before 0x55.
    for (int i = 1000; i < 1109; i++) step(8'(i), 1'b1, 1'b0, 1'b1, 1'b1, 8'(i));
    check("wrap_err", 64'(err_cnt), 64'(0));
    check("wrap_locked", 64'(locked), 64'(1));
    step(8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    check("clr_err", 64'(err_cnt), 64'(0));
    check("clr_word", 64'(word_cnt), 64'(0));
    check("clr_locked", 64'(locked), 64'(1));

    // T3/T4: single corruption, invalid cycle, error burst with clear, unlock.
    for (int k = 0; k < 8; k++) begin
      step(tbl[k].din, tbl[k].v, tbl[k].clr, 1'b1, 1'b1, tbl[k].din);
      check($sformatf("tbl%0d_locked", k), 64'(locked), 64'(tbl[k].lk));
      check($sformatf("tbl%0d_err", k), 64'(err_cnt), 64'(tbl[k].err));
      check($sformatf("tbl%0d_word", k), 64'(word_cnt), 64'(tbl[k].wc));
    end

    // Re-lock at the same rotation; counters are frozen during search.
    for (int j = 0; j < 17; j++) begin
      step(8'(8'h5C + j), 1'b1, 1'b0, 1'b1, 1'b1, 8'(8'h5C + j));
      if (j == 15) check("relock_w16", 64'(locked), 64'(0));
    end
    check("relock_locked", 64'(locked), 64'(1));
    check("relock_rot", 64'(rot), 64'(0));
    check("relock_err", 64'(err_cnt), 64'(1));
    check("relock_word", 64'(word_cnt), 64'(1));

    // T2: 3-bit slipped stream must converge to rot=3.
    step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    locked_seen = 1'b0;
    lock_m = 0;
    for (int m = 0; m < 300; m++) begin
      step(slip3(m), 1'b1, 1'b0, 1'b1, locked_seen, cnt2(m));
      if (!locked_seen && locked === 1'b1) begin
        locked_seen = 1'b1;
        lock_m = m;
      end
      if (locked_seen && m == lock_m + 40) break;
    end
    check("t2_lock_reached", 64'(locked_seen), 64'(1));
    check("t2_rot", 64'(rot), 64'(3));
    check("t2_err", 64'(err_cnt), 64'(0));
    check("t2_word", 64'(word_cnt), 64'(40));

    // T6: one-cycle reset mid-lock, with a valid word on that cycle.
    step(slip3(lock_m + 41), 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    check("t6_locked", 64'(locked), 64'(0));
    check("t6_rot", 64'(rot), 64'(0));
    check("t6_err", 64'(err_cnt), 64'(0));
    check("t6_word", 64'(word_cnt), 64'(0));
    check("t6_dout", 64'(dout), 64'(0));

    // T5: valid toggling every cycle, garbage on invalid cycles.
    for (int i = 0; i < 2000; i++) begin
      if ((i % 2) == 0) begin
        step(8'(i / 2), 1'b1, 1'b0, 1'b1, 1'b1, 8'(i / 2));
        if (i == 30) check("t5_locked_w16", 64'(locked), 64'(0));
        if (i == 32) check("t5_locked_w17", 64'(locked), 64'(1));
      end else begin
        step(8'hC3, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        if (i == 33) check("t5_locked_idle", 64'(locked), 64'(1));
      end
    end
    check("t5_err", 64'(err_cnt), 64'(0));
    check("t5_word", 64'(word_cnt), 64'(983));
    check("t5_rot", 64'(rot), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
